// File: rtl/c2_pkg.sv
// c2_pkg: shared definitions for the C2 loader and its arbiter.
//   - state_t      : loader FSM states
//   - LOADER_ACK/ERR: reply status bytes
//   - CMD_*        : command bytes understood by the arbiter
//   - word_byte_addr: word index -> word-aligned byte address
package c2_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_LEN_LO = 4'd1,
      S_LEN_HI = 4'd2,
      S_CHECK  = 4'd3,
      S_DATA   = 4'd4,
      S_WRITE  = 4'd5,
      S_REPLY  = 4'd6,
      S_DONE   = 4'd7,
      S_HOLD   = 4'd8
   } state_t;

   localparam logic [7:0] LOADER_ACK = 8'hAC;
   localparam logic [7:0] LOADER_ERR = 8'hEE;

   // Command bytes the arbiter decodes; kept here so both sides agree.
   localparam logic [7:0] CMD_1C = 8'h1C;
   localparam logic [7:0] CMD_1D = 8'h1D;
   localparam logic [7:0] CMD_CE = 8'hCE;
   localparam logic [7:0] CMD_DE = 8'hDE;

   // Cycles after grant before the first reply byte may start, so the
   // arbiter's command echo has left the UART.
   localparam int unsigned GUARD_CYCLES = 16;

   function automatic logic [17:0] word_byte_addr(input logic [15:0] idx);
      return {idx, 2'b00};
   endfunction

endpackage

// File: rtl/c2_loader_if.sv
// c2_loader_if: UART byte stream and memory write bus of the loader.
//   master modport: loader side (consumes rx, drives tx and memory writes)
//   slave  modport: UART / memory side
interface c2_loader_if #(
   parameter int ADDR_W = 32
);
   logic [7:0]        rx_data_i;
   logic              rx_ready_i;
   logic [7:0]        tx_data_o;
   logic              tx_start_o;
   logic              tx_done_i;
   logic              imem_we_o;
   logic              dmem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [31:0]       mem_wdata_o;

   modport master (
      input  rx_data_i, rx_ready_i, tx_done_i,
      output tx_data_o, tx_start_o, imem_we_o, dmem_we_o, mem_addr_o, mem_wdata_o
   );

   modport slave (
      output rx_data_i, rx_ready_i, tx_done_i,
      input  tx_data_o, tx_start_o, imem_we_o, dmem_we_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/c2_tx_seq.sv
// c2_tx_seq: sends one byte over the UART and waits for it to finish.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   abort_i      : drop any byte in progress (UART may still finish it)
//   go_i, byte_i : request to send byte_i (accepted when not busy)
//   tx_done_i    : UART finished the byte
//   tx_data_o    : byte held for the UART while busy, else 0
//   tx_start_o   : one-cycle transmit request
//   busy_o       : a byte is in flight
//   fin_o        : one-cycle pulse when the in-flight byte completes
module c2_tx_seq (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       abort_i,
   input  logic       go_i,
   input  logic [7:0] byte_i,
   input  logic       tx_done_i,
   output logic [7:0] tx_data_o,
   output logic       tx_start_o,
   output logic       busy_o,
   output logic       fin_o
);
   logic       busy_reg;
   logic       start_reg;
   logic [7:0] data_reg;

   // tx_done_i in the start cycle belongs to some earlier byte, not ours.
   assign fin_o      = busy_reg && !start_reg && tx_done_i;
   assign busy_o     = busy_reg;
   assign tx_start_o = start_reg;
   assign tx_data_o  = data_reg;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_reg  <= 1'b0;
         start_reg <= 1'b0;
         data_reg  <= 8'h00;
      end else if (abort_i) begin
         busy_reg  <= 1'b0;
         start_reg <= 1'b0;
         data_reg  <= 8'h00;
      end else if (go_i && !busy_reg) begin
         busy_reg  <= 1'b1;
         start_reg <= 1'b1;
         data_reg  <= byte_i;
      end else begin
         start_reg <= 1'b0;
         if (fin_o) begin
            busy_reg <= 1'b0;
            data_reg <= 8'h00;
         end
      end
   end
endmodule

// File: rtl/c2_loader.sv
// c2_loader: UART memory loader behind the C2 arbiter's loader grant.
// Receives len_lo, len_hi (word count N) then 4*N little-endian payload
// bytes, writes each word to IMEM or DMEM, replies status + XOR checksum
// and pulses done.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   grant_i      : loader grant from the arbiter
//   target_i     : 0 = IMEM, 1 = DMEM, sampled when grant rises
//   done_o       : one-cycle completion pulse
//   bus          : UART rx/tx and memory write signals (master side)
module c2_loader
   import c2_pkg::*;
#(
   parameter int unsigned MEM_DEPTH_WORDS = 1024,
   parameter int          ADDR_W          = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        grant_i,
   input  logic        target_i,
   output logic        done_o,
   c2_loader_if.master bus
);
   state_t      state_reg;
   logic        target_reg;
   logic [15:0] len_reg;
   logic [15:0] word_idx_reg;
   logic [1:0]  byte_idx_reg;
   logic [31:0] word_reg;
   logic [7:0]  csum_reg;
   logic [7:0]  status_reg;
   logic [4:0]  guard_reg;
   logic        reply_idx_reg;
   logic        issued_reg;

   logic        abort;
   logic        guard_ok;
   logic        tx_go;
   logic        tx_busy;
   logic        tx_fin;
   logic        write_en;

   assign abort    = !grant_i && (state_reg != S_IDLE) && (state_reg != S_HOLD);
   assign guard_ok = guard_reg >= 5'(GUARD_CYCLES);
   assign tx_go    = (state_reg == S_REPLY) && !issued_reg && guard_ok && !tx_busy;
   assign write_en = (state_reg == S_WRITE);

   assign bus.imem_we_o   = write_en && !target_reg;
   assign bus.dmem_we_o   = write_en &&  target_reg;
   assign bus.mem_addr_o  = write_en ? ADDR_W'(word_byte_addr(word_idx_reg)) : '0;
   assign bus.mem_wdata_o = write_en ? word_reg : 32'h0;
   assign done_o          = (state_reg == S_DONE);

   c2_tx_seq u_tx_seq (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .abort_i    (abort),
      .go_i       (tx_go),
      .byte_i     (reply_idx_reg ? csum_reg : status_reg),
      .tx_done_i  (bus.tx_done_i),
      .tx_data_o  (bus.tx_data_o),
      .tx_start_o (bus.tx_start_o),
      .busy_o     (tx_busy),
      .fin_o      (tx_fin)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg     <= S_IDLE;
         target_reg    <= 1'b0;
         len_reg       <= 16'h0;
         word_idx_reg  <= 16'h0;
         byte_idx_reg  <= 2'd0;
         word_reg      <= 32'h0;
         csum_reg      <= 8'h00;
         status_reg    <= 8'h00;
         guard_reg     <= 5'd0;
         reply_idx_reg <= 1'b0;
         issued_reg    <= 1'b0;
      end else if (abort) begin
         state_reg <= S_IDLE;
      end else begin
         // Guard counts cycles since grant rise, saturating once satisfied.
         if (state_reg != S_IDLE && !guard_ok)
            guard_reg <= guard_reg + 5'd1;

         case (state_reg)
            S_IDLE: begin
               if (grant_i) begin
                  target_reg    <= target_i;
                  word_idx_reg  <= 16'h0;
                  byte_idx_reg  <= 2'd0;
                  csum_reg      <= 8'h00;
                  guard_reg     <= 5'd1;
                  reply_idx_reg <= 1'b0;
                  issued_reg    <= 1'b0;
                  state_reg     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (bus.rx_ready_i) begin
                  len_reg[7:0] <= bus.rx_data_i;
                  state_reg    <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (bus.rx_ready_i) begin
                  len_reg[15:8] <= bus.rx_data_i;
                  state_reg     <= S_CHECK;
               end
            end
            S_CHECK: begin
               word_reg <= 32'h0;
               if (32'(len_reg) > MEM_DEPTH_WORDS) begin
                  status_reg <= LOADER_ERR;
                  csum_reg   <= 8'h00;
                  state_reg  <= S_REPLY;
               end else if (len_reg == 16'h0) begin
                  status_reg <= LOADER_ACK;
                  csum_reg   <= 8'h00;
                  state_reg  <= S_REPLY;
               end else begin
                  state_reg  <= S_DATA;
               end
            end
            S_DATA: begin
               if (bus.rx_ready_i) begin
                  word_reg[{byte_idx_reg, 3'b000} +: 8] <= bus.rx_data_i;
                  csum_reg     <= csum_reg ^ bus.rx_data_i;
                  byte_idx_reg <= byte_idx_reg + 2'd1;
                  if (byte_idx_reg == 2'd3)
                     state_reg <= S_WRITE;
               end
            end
            S_WRITE: begin
               word_idx_reg <= word_idx_reg + 16'd1;
               if (word_idx_reg + 16'd1 == len_reg) begin
                  status_reg <= LOADER_ACK;
                  state_reg  <= S_REPLY;
               end else begin
                  state_reg  <= S_DATA;
               end
            end
            S_REPLY: begin
               if (tx_fin) begin
                  issued_reg <= 1'b0;
                  if (!reply_idx_reg)
                     reply_idx_reg <= 1'b1;
                  else
                     state_reg <= S_DONE;
               end else if (tx_go) begin
                  issued_reg <= 1'b1;
               end
            end
            S_DONE: state_reg <= S_HOLD;
            S_HOLD: begin
               if (!grant_i)
                  state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_c2_loader.sv
// Self-checking bench for c2_loader: expected writes, reply bytes and done
// pulses are queued as each load is driven and popped as the DUT emits them.
module tb_c2_loader;
   localparam int K_WRI  = 0;
   localparam int K_WRD  = 1;
   localparam int K_TX   = 2;
   localparam int K_DONE = 3;
   localparam int K_NONE = 7;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic rst_i = 1'b1;
   logic grant_i = 1'b0;
   logic target_i = 1'b0;
   logic done_o;

   c2_loader_if #(.ADDR_W(32)) bus ();

   c2_loader #(.MEM_DEPTH_WORDS(1024), .ADDR_W(32)) dut (
      .clk_i    (clk),
      .rst_i    (rst_i),
      .grant_i  (grant_i),
      .target_i (target_i),
      .done_o   (done_o),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   ev_t sb[$];
   int  total = 0;
   int  bad = 0;
   int  cyc = 0;
   int  rise_cyc = 0;
   int  done_cnt = 0;
   int  ev_cnt = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, exp);
      end
   endtask

   task automatic push_ev(input int kind, input logic [31:0] addr, input logic [31:0] data);
      ev_t e;
      e.kind = kind; e.addr = addr; e.data = data;
      sb.push_back(e);
   endtask

   task automatic got_ev(input int kind, input logic [31:0] addr, input logic [31:0] data);
      ev_t e;
      ev_cnt++;
      $display("event kind=%0d addr=%h data=%h at cycle %0d", kind, addr, data, cyc);
      if (sb.size() == 0) begin
         chk("unexpected_event", 32'(kind), 32'(K_NONE));
      end else begin
         e = sb.pop_front();
         chk("ev_kind", 32'(kind), 32'(e.kind));
         chk("ev_addr", addr, e.addr);
         chk("ev_data", data, e.data);
      end
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (bus.imem_we_o) got_ev(K_WRI, bus.mem_addr_o, bus.mem_wdata_o);
      if (bus.dmem_we_o) got_ev(K_WRD, bus.mem_addr_o, bus.mem_wdata_o);
      if (bus.tx_start_o) begin
         got_ev(K_TX, 32'h0, {24'h0, bus.tx_data_o});
         chk("tx_guard", 32'(cyc - rise_cyc >= 16), 32'd1);
      end
      if (done_o) begin
         done_cnt++;
         got_ev(K_DONE, 32'h0, 32'h0);
      end
      if (!bus.imem_we_o && !bus.dmem_we_o) begin
         chk("idle_addr", bus.mem_addr_o, 32'h0);
         chk("idle_wdata", bus.mem_wdata_o, 32'h0);
      end
   end

   // UART transmitter model: finishes each byte 8 cycles after its start.
   initial begin
      bus.tx_done_i = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.tx_start_o) begin
            repeat (8) @(negedge clk);
            bus.tx_done_i = 1'b1;
            @(negedge clk);
            bus.tx_done_i = 1'b0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data_i  = b;
      bus.rx_ready_i = 1'b1;
      @(negedge clk);
      bus.rx_ready_i = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Raise grant, then flip target to show it was latched at grant rise.
   task automatic start_grant(input logic tgt);
      @(negedge clk);
      target_i = tgt;
      grant_i  = 1'b1;
      rise_cyc = cyc;
      @(negedge clk);
      target_i = ~tgt;
   endtask

   task automatic end_grant();
      @(negedge clk);
      grant_i = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic wait_empty(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) chk(tag, 32'(sb.size()), 32'd0);
   endtask

   task automatic push_reply(input logic [7:0] st, input logic [7:0] cs);
      push_ev(K_TX, 32'h0, {24'h0, st});
      push_ev(K_TX, 32'h0, {24'h0, cs});
      push_ev(K_DONE, 32'h0, 32'h0);
   endtask

   initial begin
      int d0;
      int e0;
      bus.rx_data_i  = 8'h00;
      bus.rx_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_imem_we", 32'(bus.imem_we_o), 32'd0);
      chk("rst_dmem_we", 32'(bus.dmem_we_o), 32'd0);
      chk("rst_tx_start", 32'(bus.tx_start_o), 32'd0);
      chk("rst_tx_data", 32'(bus.tx_data_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      rst_i = 1'b0;
      repeat (2) @(negedge clk);

      // Load 1: IMEM, two words, then grant held 100 cycles after done.
      push_ev(K_WRI, 32'h0, 32'h00500013);
      push_ev(K_WRI, 32'h4, 32'h00100093);
      push_reply(8'hAC, 8'hC0);
      d0 = done_cnt;
      start_grant(1'b0);
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
      send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
      wait_empty("load1_timeout");
      repeat (100) @(negedge clk);
      chk("load1_done_once", 32'(done_cnt - d0), 32'd1);
      end_grant();

      // Load 2: DMEM, one word.
      push_ev(K_WRD, 32'h0, 32'hDEADBEEF);
      push_reply(8'hAC, 8'h22);
      start_grant(1'b1);
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
      wait_empty("load2_timeout");
      end_grant();

      // Load 3: zero-length.
      push_reply(8'hAC, 8'h00);
      d0 = done_cnt;
      start_grant(1'b0);
      send_byte(8'h00); send_byte(8'h00);
      wait_empty("load3_timeout");
      chk("load3_done", 32'(done_cnt - d0), 32'd1);
      end_grant();

      // Load 4: one word over the limit.
      push_reply(8'hEE, 8'h00);
      start_grant(1'b0);
      send_byte(8'h01); send_byte(8'h04);
      wait_empty("load4_timeout");
      end_grant();

      // Abort: grant dropped after two payload bytes; nothing must follow.
      e0 = ev_cnt;
      start_grant(1'b0);
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22);
      @(negedge clk);
      grant_i = 1'b0;
      repeat (40) @(negedge clk);
      chk("abort_quiet", 32'(ev_cnt - e0), 32'd0);

      // Restart after abort begins again at the length bytes.
      push_ev(K_WRI, 32'h0, 32'h44332211);
      push_reply(8'hAC, 8'h44);
      start_grant(1'b0);
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      wait_empty("restart_timeout");
      end_grant();

      // Asynchronous reset in the middle of the payload.
      e0 = ev_cnt;
      start_grant(1'b1);
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hAA); send_byte(8'hBB);
      @(negedge clk);
      #2 rst_i = 1'b1;
      #1;
      chk("arst_imem_we", 32'(bus.imem_we_o), 32'd0);
      chk("arst_dmem_we", 32'(bus.dmem_we_o), 32'd0);
      chk("arst_tx_start", 32'(bus.tx_start_o), 32'd0);
      chk("arst_addr", bus.mem_addr_o, 32'h0);
      chk("arst_done", 32'(done_o), 32'd0);
      grant_i = 1'b0;
      @(negedge clk);
      rst_i = 1'b0;
      repeat (5) @(negedge clk);
      chk("arst_quiet", 32'(ev_cnt - e0), 32'd0);

      // Clean load after reset lands at address 0.
      push_ev(K_WRD, 32'h0, 32'h87654321);
      push_reply(8'hAC, 8'h87 ^ 8'h65 ^ 8'h43 ^ 8'h21);
      start_grant(1'b1);
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h21); send_byte(8'h43); send_byte(8'h65); send_byte(8'h87);
      wait_empty("post_rst_timeout");
      end_grant();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/c2_loader.md
Name: c2_loader

Overview:
- UART memory loader; sits directly downstream of the C2 arbiter's loader grant.
- While granted, it receives a length-prefixed little-endian word stream from the host and assembles 32-bit words.
- It writes the words to IMEM or DMEM as selected by the target input, then returns a status byte and a checksum byte over UART and pulses done.
- Its UART TX outputs are the arbiter's loader TX taps; its done output drives the arbiter's loader_done input.

Parameters:
- MEM_DEPTH_WORDS, 1024, maximum accepted word count per target memory.
- ADDR_W, 32, width of the byte address output.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous, active-high reset.
- grant_i  input  1  arbiter loader grant.
- target_i  input  1  0 = IMEM, 1 = DMEM; sampled when grant rises.
- rx_data_i  input  8  UART received byte.
- rx_ready_i  input  1  one-cycle strobe; rx_data_i is valid in that cycle.
- tx_data_o  output  8  byte to transmit.
- tx_start_o  output  1  one-cycle transmit request.
- tx_done_i  input  1  one-cycle pulse when the UART finishes a byte.
- done_o  output  1  one-cycle completion pulse.
- imem_we_o  output  1  IMEM word write strobe.
- dmem_we_o  output  1  DMEM word write strobe.
- mem_addr_o  output  ADDR_W  byte address, word aligned.
- mem_wdata_o  output  32  assembled write word.

Behaviour:
- Reset: all outputs are 0, state is S_IDLE, all counters and the checksum are cleared.
- Protocol after grant: len_lo, len_hi (N = 16-bit word count), then 4*N payload bytes, least significant byte first within each word.
- S_IDLE: when grant_i = 1, latch target_i, clear word_idx, byte_idx and csum, go to S_LEN_LO.
- S_LEN_LO: on rx_ready_i, latch len[7:0], go to S_LEN_HI.
- S_LEN_HI: on rx_ready_i, latch len[15:8], go to S_CHECK.
- S_CHECK (one cycle):
  - len > MEM_DEPTH_WORDS: status = 0xEE, go to S_REPLY (no writes are issued; the remaining payload bytes are ignored and the host must not send them).
  - len == 0: status = 0xAC, csum = 0x00, go to S_REPLY.
  - Otherwise go to S_DATA.
- S_DATA:
  - On each rx_ready_i, shift the byte into word[8*byte_idx +: 8] and update csum ^= byte.
  - byte_idx counts 0..3. On byte_idx == 3, go to S_WRITE.
- S_WRITE (one cycle):
  - Assert exactly one strobe: imem_we_o if target = 0, dmem_we_o if target = 1.
  - mem_addr_o = word_idx << 2; mem_wdata_o = the assembled word.
  - The write occurs one cycle after the rx_ready of the word's 4th byte.
  - Increment word_idx. If word_idx + 1 == len, set status = 0xAC and go to S_REPLY; else return to S_DATA.
  - A new rx_ready_i cannot arrive in this cycle because of UART byte spacing; none needs to be handled.
- mem_addr_o and mem_wdata_o are 0 whenever no strobe is asserted.
- S_REPLY: send two bytes in sequence, status then csum (csum is 0x00 on error).
  - For each byte: hold tx_data_o and pulse tx_start_o for one cycle, then wait for tx_done_i.
  - The first start is issued no earlier than 16 cycles after grant rise. This guard lets the arbiter's command echo clear the UART.
  - After the second tx_done_i, go to S_DONE.
- S_DONE: done_o = 1 for exactly one cycle, go to S_HOLD.
- S_HOLD: outputs idle; return to S_IDLE when grant_i = 0. A held-high grant never restarts a load.
- Grant drops in any state other than S_IDLE/S_HOLD: abort on the next edge to S_IDLE.
  - No further strobes, no done, tx_start_o = 0.
  - A byte already started may finish on the UART.
- rx_ready_i is ignored in S_IDLE, S_CHECK, S_WRITE, S_REPLY, S_DONE and S_HOLD.
- Asynchronous reset mid-transfer returns to S_IDLE immediately with all outputs 0.
- word_idx is 16 bits wide; the address is zero-extended to ADDR_W.

Decomposition:
- Package c2_pkg holds:
  - the loader state_t enum;
  - the status constants LOADER_ACK = 8'hAC and LOADER_ERR = 8'hEE;
  - the command constants 8'h1C, 8'h1D, 8'hCE, 8'hDE shared with the arbiter.
- One natural sub-module, c2_tx_seq: sends a byte and waits for done, used twice per reply.
- Word assembly stays inline.

Test Plan:
- Load target 0, N = 2, bytes 02 00 | 13 00 50 00 | 93 00 10 00:
  - imem_we_o pulses at addr 0x0 with data 0x00500013, then at addr 0x4 with data 0x00100093;
  - dmem_we_o never asserts;
  - reply is AC, then csum 0xC0;
  - done_o pulses once.
- Target 1, N = 1, bytes 01 00 EF BE AD DE: dmem_we_o at addr 0x0 with data 0xDEADBEEF; reply AC then 0x22.
- N = 0 (00 00): no strobes; reply AC then 00; done_o pulses.
- N = 0x0401 with MEM_DEPTH_WORDS = 1024: no strobes; reply EE then 00; done_o pulses.
- Grant dropped after 2 payload bytes: no strobe, no tx_start_o, no done_o; the next grant restarts from S_LEN_LO.
- Grant held high for 100 cycles after done: exactly one done_o, no further tx_start_o.
- rst_i asserted in S_DATA: all outputs 0 asynchronously; the next grant performs a clean load at addr 0x0.
